axis_packet_fifo: RTL and testbench



---
 rtl/axis_packet_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_axis_packet_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_fifo.sv
// AXI4-Stream FIFO with registered output, threshold flags and packet accounting.
// Define AXIS_PKT_FIFO_STORE_FWD_EN for store-and-forward with oversize-packet drop.
module axis_packet_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int USER_WIDTH = 1,
    parameter int DEST_WIDTH = 4,
    parameter int ID_WIDTH   = 4,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0]       s_axis_tkeep,
    input  logic                          s_axis_tlast,
    input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
    input  logic [ID_WIDTH-1:0]           s_axis_tid,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic [DEST_WIDTH-1:0]         m_axis_tdest,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(DEPTH):0]        pkt_count,
    output logic                          pkt_drop
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int WW = DATA_WIDTH + 2 * KW + 1 + DEST_WIDTH + ID_WIDTH + USER_WIDTH;

    logic [WW-1:0] mem [DEPTH];

    logic [WW-1:0] s_word;
    logic [WW-1:0] m_word_q, m_word_d;
    logic          m_valid_q, m_valid_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic [PW-1:0] pkt_count_q, pkt_count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          pkt_drop_q, pkt_drop_d;

    logic          s_ready;
    logic          mem_we;
    logic          drop_evt;
    logic          commit_evt;
    logic          readable;
    logic          out_fire;
    logic          load;
    logic [PW-1:0] drop_amt;
    logic [PW-1:0] rewind_ptr;

    assign s_word = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
                     s_axis_tdest, s_axis_tid, s_axis_tuser};

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    typedef enum logic {ST_ACCUM, ST_DROP} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] commit_ptr_q, commit_ptr_d;
    logic [PW-1:0] pending;

    assign pending = wr_ptr_q - commit_ptr_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= ST_ACCUM;
            commit_ptr_q <= '0;
        end else begin
            state_q      <= state_d;
            commit_ptr_q <= commit_ptr_d;
        end
    end

    // A packet that fills the whole memory without its tlast can never be committed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCUM: if (mem_we && !s_axis_tlast && (pending + PW'(1)) == PW'(DEPTH))
                          state_d = ST_DROP;
            ST_DROP:  if (drop_evt) state_d = ST_ACCUM;
            default:  state_d = ST_ACCUM;
        endcase
    end

    always_comb begin
        s_ready  = 1'b1;
        mem_we   = 1'b0;
        drop_evt = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                s_ready = !full_q;
                mem_we  = s_axis_tvalid && !full_q;
            end
            ST_DROP:  drop_evt = s_axis_tvalid && s_axis_tlast;
            default:  s_ready = 1'b1;
        endcase
    end

    always_comb begin
        commit_ptr_d = commit_ptr_q;
        if (commit_evt)
            commit_ptr_d = wr_ptr_q + PW'(1);
    end

    assign readable   = (rd_ptr_q != commit_ptr_q);
    assign drop_amt   = drop_evt ? pending : '0;
    assign rewind_ptr = commit_ptr_q;
    assign pkt_drop_d = drop_evt;
`else
    assign s_ready    = !full_q;
    assign mem_we     = s_axis_tvalid && !full_q;
    assign drop_evt   = 1'b0;
    assign readable   = (rd_ptr_q != wr_ptr_q);
    assign drop_amt   = '0;
    assign rewind_ptr = wr_ptr_q;
    assign pkt_drop_d = 1'b0;
`endif

    assign commit_evt = mem_we && s_axis_tlast;
    assign out_fire   = m_valid_q && m_axis_tready;
    assign load       = (!m_valid_q || m_axis_tready) && readable;

    always_ff @(posedge aclk) begin
        if (mem_we)
            mem[wr_ptr_q[AW-1:0]] <= s_word;
    end

    // Count covers memory plus the output register; flags are registered from the next count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (drop_evt)
            wr_ptr_d = rewind_ptr;
        else if (mem_we)
            wr_ptr_d = wr_ptr_q + PW'(1);

        rd_ptr_d  = rd_ptr_q;
        m_word_d  = m_word_q;
        m_valid_d = m_valid_q;
        if (load) begin
            rd_ptr_d  = rd_ptr_q + PW'(1);
            m_word_d  = mem[rd_ptr_q[AW-1:0]];
            m_valid_d = 1'b1;
        end else if (out_fire) begin
            m_valid_d = 1'b0;
        end

        count_d     = count_q + PW'(mem_we) - PW'(out_fire) - drop_amt;
        pkt_count_d = pkt_count_q + PW'(commit_evt) - PW'(out_fire && m_axis_tlast);

        full_d  = (count_d == PW'(DEPTH));
        empty_d = (count_d == '0);
        af_d    = (count_d >= PW'(AF_THRESH));
        ae_d    = (count_d <= PW'(AE_THRESH));
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            m_word_q    <= '0;
            m_valid_q   <= 1'b0;
            count_q     <= '0;
            pkt_count_q <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            pkt_drop_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            m_word_q    <= m_word_d;
            m_valid_q   <= m_valid_d;
            count_q     <= count_d;
            pkt_count_q <= pkt_count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            pkt_drop_q  <= pkt_drop_d;
        end
    end

    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
            m_axis_tdest, m_axis_tid, m_axis_tuser} = m_word_q;

    assign s_axis_tready = s_ready;
    assign m_axis_tvalid = m_valid_q;
    assign fifo_count    = count_q;
    assign fifo_full     = full_q;
    assign fifo_empty    = empty_q;
    assign almost_full   = af_q;
    assign almost_empty  = ae_q;
    assign pkt_count     = pkt_count_q;
    assign pkt_drop      = pkt_drop_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// Directed bench for axis_packet_fifo with a beat scoreboard and a count/packet model.
// Store-and-forward scenarios are built when AXIS_PKT_FIFO_STORE_FWD_EN is defined.
module tb_axis_packet_fifo;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  dest;
        logic [3:0]  id;
        logic [0:0]  user;
    } beat_t;

    logic        aclk = 1'b0;
    logic        areset;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tstrb;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast;
    logic [3:0]  s_axis_tdest;
    logic [3:0]  s_axis_tid;
    logic [0:0]  s_axis_tuser;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [3:0]  m_axis_tdest;
    logic [3:0]  m_axis_tid;
    logic [0:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [4:0]  fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        almost_full;
    logic        almost_empty;
    logic [4:0]  pkt_count;
    logic        pkt_drop;

    axis_packet_fifo dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tid    (s_axis_tid),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdest  (m_axis_tdest),
        .m_axis_tid    (m_axis_tid),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fifo_count    (fifo_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .almost_full   (almost_full),
        .almost_empty  (almost_empty),
        .pkt_count     (pkt_count),
        .pkt_drop      (pkt_drop)
    );

    always #5 aclk = ~aclk;

    int    total = 0;
    int    bad   = 0;
    beat_t sb[$];
    beat_t pend[$];
    int    model_count = 0;
    int    model_pkts  = 0;
    bit    model_drop  = 1'b0;
    bit    exp_drop    = 1'b0;
`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
    bit    store_fwd = 1'b1;
`else
    bit    store_fwd = 1'b0;
`endif

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int i, input bit last);
        logic [31:0] v;
        beat_t b;
        v      = i;
        b.data = v;
        b.strb = v[3:0];
        b.keep = ~v[3:0];
        b.last = last;
        b.dest = v[7:4];
        b.id   = v[3:0] ^ 4'h5;
        b.user = v[0];
        return b;
    endfunction

    task automatic model_reset();
        sb.delete();
        pend.delete();
        model_count = 0;
        model_pkts  = 0;
        model_drop  = 1'b0;
        exp_drop    = 1'b0;
    endtask

    // Cut-through words become visible on accept; store-and-forward only on their tlast.
    task automatic model_accept(input beat_t b);
        if (!store_fwd) begin
            sb.push_back(b);
            model_count++;
            if (b.last) model_pkts++;
        end else if (!model_drop) begin
            pend.push_back(b);
            model_count++;
            if (b.last) begin
                while (pend.size() > 0) sb.push_back(pend.pop_front());
                model_pkts++;
            end else if (pend.size() == 16) begin
                model_drop = 1'b1;
            end
        end else if (b.last) begin
            model_count = model_count - pend.size();
            pend.delete();
            model_drop = 1'b0;
            exp_drop   = 1'b1;
        end
    endtask

    // One cycle, entered and left at a falling edge.
    task automatic apply_stimulus(input bit v, input beat_t b, input bit rdy, output bit accepted);
        bit    rf;
        beat_t got;
        beat_t exp;
        s_axis_tvalid = v;
        {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
         s_axis_tdest, s_axis_tid, s_axis_tuser} = b;
        m_axis_tready = rdy;
        #1;
        accepted = v && s_axis_tready;
        rf       = m_axis_tvalid && rdy;
        exp_drop = 1'b0;
        if (rf) begin
            got = {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast,
                   m_axis_tdest, m_axis_tid, m_axis_tuser};
            if (sb.size() == 0) begin
                check_output("unexpected_beat", m_axis_tvalid, 0);
            end else begin
                exp = sb.pop_front();
                check_output("out_beat", got, exp);
                model_count--;
                if (exp.last) model_pkts--;
            end
        end
        if (accepted) model_accept(b);
        @(posedge aclk);
        #1;
        check_output("fifo_count", fifo_count, model_count);
        check_output("fifo_full", fifo_full, model_count == 16);
        check_output("fifo_empty", fifo_empty, model_count == 0);
        check_output("almost_full", almost_full, model_count >= 14);
        check_output("almost_empty", almost_empty, model_count <= 2);
        check_output("pkt_count", pkt_count, model_pkts);
        check_output("s_tready", s_axis_tready, model_drop ? 1'b1 : (model_count != 16));
        check_output("pkt_drop", pkt_drop, exp_drop);
        @(negedge aclk);
    endtask

    task automatic drain(input int max_cycles);
        bit acc;
        for (int k = 0; k < max_cycles && (model_count != 0 || sb.size() != 0); k++)
            apply_stimulus(1'b0, '0, 1'b1, acc);
        check_output("drained_empty", fifo_count, 0);
    endtask

    task automatic check_reset_values();
        check_output("rst_m_valid", m_axis_tvalid, 0);
        check_output("rst_m_data", m_axis_tdata, 0);
        check_output("rst_count", fifo_count, 0);
        check_output("rst_tready", s_axis_tready, 1);
        check_output("rst_empty", fifo_empty, 1);
        check_output("rst_full", fifo_full, 0);
        check_output("rst_af", almost_full, 0);
        check_output("rst_ae", almost_empty, 1);
        check_output("rst_pkt_count", pkt_count, 0);
        check_output("rst_pkt_drop", pkt_drop, 0);
    endtask

    initial begin
        bit acc;
        int sent;
        int guard;

        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast,
         s_axis_tdest, s_axis_tid, s_axis_tuser} = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        check_reset_values();
        @(negedge aclk);
        areset = 1'b0;
        model_reset();

        // Fill with the output stalled; store-and-forward uses 4-beat packets so nothing drops.
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, mk_beat(i, store_fwd && (i % 4 == 3)), 1'b0, acc);
            if (!store_fwd && i == 0) check_output("ct_latency_e", m_axis_tvalid, 0);
            if (!store_fwd && i == 1) check_output("ct_latency_e1", m_axis_tvalid, 1);
        end
        apply_stimulus(1'b1, mk_beat(16, 1'b0), 1'b0, acc);
        check_output("no_accept_when_full", acc, 0);

        // Both sides active from full: full blocks the first beat, then count holds steady.
        for (int k = 0; k < 20; k++)
            apply_stimulus(1'b1, mk_beat(200 + k, k % 4 == 3), 1'b1, acc);
        drain(40);

        // Random handshakes on both sides.
        sent  = 0;
        guard = 0;
        while (sent < 100 && guard < 3000) begin
            apply_stimulus(1'($urandom_range(0, 1)), mk_beat(sent, sent % 5 == 4),
                           1'($urandom_range(0, 1)), acc);
            if (acc) sent++;
            guard++;
        end
        check_output("stream_sent", sent, 100);
        drain(200);

        // Asynchronous reset with a partial packet stored.
        for (int i = 0; i < 7; i++)
            apply_stimulus(1'b1, mk_beat(300 + i, 1'b0), 1'b0, acc);
        #2;
        areset = 1'b1;
        #1;
        check_reset_values();
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
        apply_stimulus(1'b1, mk_beat(400, 1'b0), 1'b0, acc);
        apply_stimulus(1'b1, mk_beat(401, 1'b1), 1'b0, acc);
        drain(20);

`ifdef AXIS_PKT_FIFO_STORE_FWD_EN
        // Output withheld until tlast, even across an input gap.
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, mk_beat(500 + i, 1'b0), 1'b0, acc);
            check_output("sf_withheld", m_axis_tvalid, 0);
        end
        apply_stimulus(1'b0, '0, 1'b0, acc);
        apply_stimulus(1'b0, '0, 1'b0, acc);
        apply_stimulus(1'b1, mk_beat(503, 1'b1), 1'b0, acc);
        check_output("sf_tlast_edge", m_axis_tvalid, 0);
        apply_stimulus(1'b0, '0, 1'b0, acc);
        check_output("sf_after_tlast", m_axis_tvalid, 1);
        drain(20);

        // Oversize packet is swallowed; the next packet goes through intact.
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, mk_beat(600 + i, i == 19), 1'b0, acc);
            check_output("sf_big_accept", acc, 1);
        end
        apply_stimulus(1'b0, '0, 1'b0, acc);
        apply_stimulus(1'b1, mk_beat(700, 1'b0), 1'b0, acc);
        apply_stimulus(1'b1, mk_beat(701, 1'b1), 1'b0, acc);
        drain(20);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
